axi2ahb_burst_ctrl: RTL and testbench

Parametrised AHB-manager burst engine for the AXI-to-AHB bridge. It takes one latched AXI-style command (address, length, burst type, direction) and issues the matching AHB burst. It supports configurable address and data width, correct WRAP4/8/16 address wrapping, INCR splitting at 1 KB boundaries, BUSY insertion when the data side stalls, HREADY wait states, and HRESP error abort. It sits between the AXI command/data buffers and the AHB bus; data movement stays in the buffers, and this block only sequences address phases and reports beat completion.

---
 rtl/axi2ahb_burst_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_axi2ahb_burst_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi2ahb_burst_ctrl.sv
`timescale 1ns/1ps
// axi2ahb_burst_ctrl: AHB manager burst sequencer for the AXI-to-AHB bridge.
// It takes one latched command, drives the AHB address phases for it and
// reports each completed data phase. Data itself stays in the bridge buffers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready_o=1, waiting for a command
// ADDR  | issuing address phases (NONSEQ/SEQ, BUSY/IDLE when data stalls)
// DRAIN | all addresses issued or aborted, waiting for the last data phase
// DONE  | one-cycle done_valid_o pulse, done_err_o flags error or reject
//
// The next address phase is registered: the HTRANS shown in a cycle was
// chosen from beat_avail_i and HREADY at the previous rising edge. The one
// exception is an ERROR response, which forces HTRANS to IDLE in its first
// cycle without waiting for a clock edge.
module axi2ahb_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [1:0]            cmd_burst_i,
  input  logic                  beat_avail_i,
  output logic                  beat_ack_o,
  output logic                  beat_last_o,
  output logic                  done_valid_o,
  output logic                  done_err_o
);

  localparam int SZ    = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic [2:0]              hburst_q;
  logic [1:0]              htrans_q;
  logic                    hwrite_q;
  logic [7:0]              len_q;
  logic                    fixed_q;
  logic                    wrap_q;
  logic [7:0]              issue_cnt;
  logic [7:0]              data_cnt;
  logic                    dphase;
  logic                    err_q;

  logic                    err_now;
  logic                    accepted;
  logic                    last_accept;
  logic                    first_pending;
  logic                    new_page;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [ADDR_WIDTH-1:0]   issue_addr;
  logic                    cmd_fixed;
  logic                    cmd_wrap;
  logic                    len_ok;
  logic [1:0]              len_code;
  logic [10:0]             span;
  logic [10:0]             end_off;
  logic [2:0]              cmd_hburst;

  // Address-phase bookkeeping and next-address arithmetic
  always_comb begin
    err_now       = HRESP & ~HREADY;
    accepted      = htrans_q[1] & HREADY;
    last_accept   = accepted && (issue_cnt == len_q);
    first_pending = (issue_cnt == 8'd0) && !accepted;
    wrap_mask     = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << SZ) - ADDR_WIDTH'(1);
    addr_inc      = haddr_q + ADDR_WIDTH'(BYTES);
    if (fixed_q)
      addr_next = haddr_q;
    else if (wrap_q)
      addr_next = (haddr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    else
      addr_next = addr_inc;
    issue_addr = accepted ? addr_next : haddr_q;
    // Only undefined-length INCR can cross a 1 KB page; restart it with NONSEQ
    new_page   = (hburst_q == 3'b001) && (issue_addr[9:0] == 10'd0);
  end

  // Command decode: HBURST choice and WRAP length legality
  always_comb begin
    cmd_fixed = (cmd_burst_i == 2'b00);
    cmd_wrap  = (cmd_burst_i == 2'b10);
    len_ok    = (cmd_len_i == 8'd3) || (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);
    case (cmd_len_i)
      8'd3:    len_code = 2'b01;
      8'd7:    len_code = 2'b10;
      default: len_code = 2'b11;
    endcase
    span    = (11'(cmd_len_i[3:0]) + 11'd1) << SZ;
    end_off = 11'(cmd_addr_i[9:0]) + span;
    if (cmd_fixed)
      cmd_hburst = 3'b000;
    else if (cmd_wrap)
      cmd_hburst = {len_code, 1'b0};
    else if (len_ok && (end_off <= 11'd1024))
      cmd_hburst = {len_code, 1'b1};
    else
      cmd_hburst = 3'b001;
  end

  // Burst sequencer: command latch, address issue, drain and retire
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      haddr_q   <= '0;
      hburst_q  <= 3'b000;
      htrans_q  <= T_IDLE;
      hwrite_q  <= 1'b0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      wrap_q    <= 1'b0;
      issue_cnt <= '0;
      data_cnt  <= '0;
      dphase    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (beat_ack_o)
        data_cnt <= data_cnt + 8'd1;
      if (HREADY)
        dphase <= accepted;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            len_q     <= cmd_len_i;
            fixed_q   <= cmd_fixed;
            wrap_q    <= cmd_wrap;
            issue_cnt <= '0;
            data_cnt  <= '0;
            dphase    <= 1'b0;
            if (cmd_wrap && !len_ok) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q    <= 1'b0;
              haddr_q  <= cmd_addr_i;
              hburst_q <= cmd_hburst;
              hwrite_q <= cmd_write_i;
              htrans_q <= beat_avail_i ? T_NONSEQ : T_IDLE;
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (err_now) begin
            err_q    <= 1'b1;
            htrans_q <= T_IDLE;
            state    <= S_DRAIN;
          end else if (HREADY) begin
            if (accepted)
              issue_cnt <= issue_cnt + 8'd1;
            if (last_accept) begin
              htrans_q <= T_IDLE;
              state    <= S_DRAIN;
            end else begin
              haddr_q <= issue_addr;
              if (beat_avail_i)
                htrans_q <= (first_pending || fixed_q || new_page) ? T_NONSEQ : T_SEQ;
              else
                htrans_q <= (first_pending || fixed_q) ? T_IDLE : T_BUSY;
            end
          end
        end
        S_DRAIN: begin
          if (err_now)
            err_q <= 1'b1;
          if (HREADY || !dphase)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign HADDR        = haddr_q;
  assign HBURST       = hburst_q;
  assign HSIZE        = 3'(SZ);
  assign HWRITE       = hwrite_q;
  assign HTRANS       = err_now ? T_IDLE : htrans_q;
  assign cmd_ready_o  = (state == S_IDLE);
  assign beat_ack_o   = dphase & HREADY;
  assign beat_last_o  = beat_ack_o && (data_cnt == len_q);
  assign done_valid_o = (state == S_DONE);
  assign done_err_o   = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_axi2ahb_burst_ctrl.sv
`timescale 1ns/1ps
// Directed bench for axi2ahb_burst_ctrl: a 32-bit instance for most bursts
// and a 64-bit instance for the WRAP8 case. Inputs change and outputs are
// sampled on the falling edge (+1 ns).
module tb_axi2ahb_burst_ctrl;

  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        HREADY = 1'b1, HRESP = 1'b0, beat_avail = 1'b0;
  logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [1:0]  cmd_burst = '0;

  logic [31:0] haddr_a, haddr_b;
  logic [2:0]  hburst_a, hburst_b, hsize_a, hsize_b;
  logic [1:0]  htrans_a, htrans_b;
  logic        hwrite_a, hwrite_b, rdy_a, rdy_b;
  logic        ack_a, ack_b, last_a, last_b, done_a, done_b, derr_a, derr_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi2ahb_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET),
    .HADDR(haddr_a), .HBURST(hburst_a), .HSIZE(hsize_a), .HTRANS(htrans_a),
    .HWRITE(hwrite_a), .HREADY(HREADY), .HRESP(HRESP),
    .cmd_valid_i(cmd_valid_a), .cmd_ready_o(rdy_a), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_burst_i(cmd_burst),
    .beat_avail_i(beat_avail), .beat_ack_o(ack_a), .beat_last_o(last_a),
    .done_valid_o(done_a), .done_err_o(derr_a));

  axi2ahb_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .HADDR(haddr_b), .HBURST(hburst_b), .HSIZE(hsize_b), .HTRANS(htrans_b),
    .HWRITE(hwrite_b), .HREADY(HREADY), .HRESP(HRESP),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(rdy_b), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_burst_i(cmd_burst),
    .beat_avail_i(beat_avail), .beat_ack_o(ack_b), .beat_last_o(last_b),
    .done_valid_o(done_b), .done_err_o(derr_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic rdy, input logic resp, input logic av);
    @(negedge ACLK);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    HREADY = rdy;
    HRESP = resp;
    beat_avail = av;
    #1;
  endtask

  task automatic issue(input bit big, input logic wr, input logic [31:0] ad,
                       input logic [7:0] len, input logic [1:0] bt);
    @(negedge ACLK);
    cmd_write = wr;
    cmd_addr = ad;
    cmd_len = len;
    cmd_burst = bt;
    HREADY = 1'b1;
    HRESP = 1'b0;
    beat_avail = 1'b1;
    if (big) cmd_valid_b = 1'b1;
    else     cmd_valid_a = 1'b1;
    #1;
    chk("handshake ready", big ? 32'(rdy_b) : 32'(rdy_a), 32'd1);
  endtask

  task automatic a_cyc(input string tag, input logic [1:0] tr, input logic [31:0] ad,
                       input logic ack, input logic last);
    chk({tag, " trans"}, 32'(htrans_a), 32'(tr));
    if (tr != TI) chk({tag, " addr"}, haddr_a, ad);
    chk({tag, " ack"}, 32'(ack_a), 32'(ack));
    chk({tag, " last"}, 32'(last_a), 32'(last));
  endtask

  initial begin
    logic [1:0]  t3_tr[6]  = '{TN, TS, TN, TS, TS, TS};
    logic [31:0] t3_ad[6]  = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h408, 32'h40C};
    logic [31:0] w8[8]     = '{32'h38, 32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30};
    logic        t4_rdy[13] = '{1,1,1,1,1,1,1,0,1,1,1,1,1};
    logic        t4_av[13]  = '{1,1,0,0,1,1,1,1,1,1,1,1,1};
    logic [1:0]  t4_tr[13]  = '{TN,TS,TS,TB,TB,TS,TS,TS,TS,TS,TS,TI,TI};
    logic [31:0] t4_ad[13]  = '{32'h00,32'h04,32'h08,32'h0C,32'h0C,32'h0C,32'h10,
                                32'h14,32'h14,32'h18,32'h1C,32'h0,32'h0};
    logic        t4_ack[13] = '{0,1,1,1,0,0,1,0,1,1,1,1,0};
    int acks;
    int dones;

    // reset values
    tick(1, 0, 0);
    chk("rst haddr", haddr_a, 32'h0);
    chk("rst hburst", 32'(hburst_a), 32'd0);
    chk("rst htrans", 32'(htrans_a), 32'(TI));
    chk("rst hwrite", 32'(hwrite_a), 32'd0);
    chk("rst ready", 32'(rdy_a), 32'd1);
    chk("rst ack", 32'(ack_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst derr", 32'(derr_a), 32'd0);
    chk("hsize32", 32'(hsize_a), 32'd2);
    chk("hsize64", 32'(hsize_b), 32'd3);
    @(negedge ACLK);
    ARESET = 1'b0;

    // INCR4 write at 0x100, no stalls
    issue(0, 1, 32'h100, 8'd3, 2'b01);
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, 1);
      a_cyc($sformatf("incr4 c%0d", i), (i == 1) ? TN : (i <= 4) ? TS : TI,
            32'h100 + 32'(4 * (i - 1)), (i >= 2 && i <= 5), (i == 5));
      if (i == 1) begin
        chk("incr4 hburst", 32'(hburst_a), 32'd3);
        chk("incr4 hwrite", 32'(hwrite_a), 32'd1);
        chk("incr4 ready low", 32'(rdy_a), 32'd0);
      end
      if (i == 5) chk("incr4 no early done", 32'(done_a), 32'd0);
      if (i == 6) begin
        chk("incr4 done", 32'(done_a), 32'd1);
        chk("incr4 derr", 32'(derr_a), 32'd0);
        chk("incr4 ready in done", 32'(rdy_a), 32'd0);
      end
    end
    tick(1, 0, 0);
    chk("incr4 ready back", 32'(rdy_a), 32'd1);
    chk("incr4 done gone", 32'(done_a), 32'd0);

    // WRAP8 read at 0x38 on the 64-bit instance
    issue(1, 0, 32'h38, 8'd7, 2'b10);
    acks = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0, 1);
      acks += int'(ack_b);
      if (i <= 8) begin
        chk($sformatf("wrap8 c%0d trans", i), 32'(htrans_b), 32'((i == 1) ? TN : TS));
        chk($sformatf("wrap8 c%0d addr", i), haddr_b, w8[i-1]);
      end
      if (i == 1) chk("wrap8 hburst", 32'(hburst_b), 32'd4);
      if (i == 9) begin
        chk("wrap8 idle", 32'(htrans_b), 32'(TI));
        chk("wrap8 last", 32'(last_b), 32'd1);
      end
      if (i == 10) begin
        chk("wrap8 done", 32'(done_b), 32'd1);
        chk("wrap8 derr", 32'(derr_b), 32'd0);
      end
    end
    chk("wrap8 acks", 32'(acks), 32'd8);

    // undefined INCR, len 5, crossing the 1 KB page at 0x400
    issue(0, 1, 32'h3F8, 8'd5, 2'b11);
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, 1);
      if (i <= 6)
        a_cyc($sformatf("incr6 c%0d", i), t3_tr[i-1], t3_ad[i-1], (i >= 2), 1'b0);
      else
        a_cyc($sformatf("incr6 c%0d", i), TI, 32'h0, (i == 7), (i == 7));
      if (i == 1) chk("incr6 hburst", 32'(hburst_a), 32'd1);
      if (i == 8) chk("incr6 done", 32'(done_a), 32'd1);
    end

    // INCR8 with two data-side stalls and one wait state
    issue(0, 1, 32'h0, 8'd7, 2'b01);
    acks = 0;
    for (int i = 1; i <= 13; i++) begin
      tick(t4_rdy[i-1], 0, t4_av[i-1]);
      acks += int'(ack_a);
      a_cyc($sformatf("incr8 c%0d", i), t4_tr[i-1], t4_ad[i-1], t4_ack[i-1], (i == 12));
      if (i == 1) chk("incr8 hburst", 32'(hburst_a), 32'd5);
      if (i == 13) chk("incr8 done", 32'(done_a), 32'd1);
    end
    chk("incr8 acks", 32'(acks), 32'd8);

    // WRAP16 read with an ERROR response on beat 2
    issue(0, 0, 32'h40, 8'd15, 2'b10);
    tick(1, 0, 1);
    a_cyc("err c1", TN, 32'h40, 0, 0);
    chk("err hburst", 32'(hburst_a), 32'd6);
    tick(1, 0, 1);
    a_cyc("err c2", TS, 32'h44, 1, 0);
    tick(0, 1, 1);
    a_cyc("err c3", TI, 32'h0, 0, 0);
    tick(1, 1, 1);
    a_cyc("err c4", TI, 32'h0, 1, 0);
    chk("err no done yet", 32'(done_a), 32'd0);
    tick(1, 0, 1);
    a_cyc("err c5", TI, 32'h0, 0, 0);
    chk("err done", 32'(done_a), 32'd1);
    chk("err derr", 32'(derr_a), 32'd1);

    // illegal WRAP length is rejected without bus activity
    issue(0, 0, 32'h80, 8'd5, 2'b10);
    tick(1, 0, 1);
    chk("rej trans", 32'(htrans_a), 32'(TI));
    chk("rej done", 32'(done_a), 32'd1);
    chk("rej derr", 32'(derr_a), 32'd1);
    tick(1, 0, 1);
    chk("rej trans2", 32'(htrans_a), 32'(TI));
    chk("rej ready", 32'(rdy_a), 32'd1);

    // reset mid-burst
    issue(0, 1, 32'h200, 8'd3, 2'b01);
    tick(1, 0, 1);
    tick(1, 0, 1);
    chk("arst pre trans", 32'(htrans_a), 32'(TS));
    ARESET = 1'b1;
    #1;
    chk("arst trans", 32'(htrans_a), 32'(TI));
    chk("arst haddr", haddr_a, 32'h0);
    chk("arst hburst", 32'(hburst_a), 32'd0);
    chk("arst hwrite", 32'(hwrite_a), 32'd0);
    chk("arst ack", 32'(ack_a), 32'd0);
    chk("arst ready", 32'(rdy_a), 32'd1);
    tick(1, 0, 1);
    @(negedge ACLK);
    ARESET = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 1);
      dones += int'(done_a);
    end
    chk("arst no done", 32'(dones), 32'd0);
    chk("arst trans idle", 32'(htrans_a), 32'(TI));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
